// File: rtl/dram_bank_timing_tracker.sv
// rtl/dram_bank_timing_tracker.sv - per-bank DDR4 open/closed state, timing legality and tREFI tracking
// Optional macro DRAM_REF_POSTPONE_EN: keep a 0..8 refresh-debt counter instead of a single ref_req flag.
module dram_bank_timing_tracker #(
   parameter int NUM_BANKS = 16,
   parameter int ROW_W     = 15,
   parameter int CNT_W     = 10,
   parameter int T_RCD     = 10,
   parameter int T_RAS     = 45,
   parameter int T_RP      = 10,
   parameter int T_RFC     = 172,
   parameter int T_REFI    = 250,
   parameter int T_WL      = 11,
   parameter int T_BURST   = 4,
   parameter int T_WR      = 12
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         cmd_valid,
   input  logic [2:0]                   cmd_type,
   input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
   input  logic [ROW_W-1:0]             cmd_row,
   output logic                         cmd_legal,
   output logic                         cmd_row_hit,
   output logic                         illegal_cmd,
   output logic [NUM_BANKS-1:0]         bank_open,
   output logic                         refreshing,
   output logic                         ref_req,
   output logic                         ref_overflow
);
   localparam int BW = $clog2(NUM_BANKS);
   localparam logic [2:0] C_ACT = 3'd0, C_RD = 3'd1, C_WR = 3'd2, C_PRE = 3'd3, C_PREA = 3'd4, C_REF = 3'd5;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic [1:0] {B_CLOSED, B_ACTIVATING, B_OPEN, B_PRECHARGING} bank_state_t;

   bank_state_t          st_q  [NUM_BANKS];
   logic [CNT_W-1:0]     cnt_q [NUM_BANKS];
   logic [CNT_W-1:0]     ras_q [NUM_BANKS];
   logic [CNT_W-1:0]     wr_q  [NUM_BANKS];
   logic [ROW_W-1:0]     row_q [NUM_BANKS];
   logic [CNT_W-1:0]     ref_cnt_q;
   logic [CNT_W-1:0]     timer_q;
   logic [NUM_BANKS-1:0] is_closed, is_open, is_busy, pre_ok;
   logic [NUM_BANKS-1:0] act_go, wr_go, pre_go;
   logic                 accept, ref_acc, wrap;

   function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
      return (v == '0) ? v : v - ONE;
   endfunction

   always_comb begin
      is_closed = '0;
      is_open   = '0;
      is_busy   = '0;
      pre_ok    = '0;
      bank_open = '0;
      act_go    = '0;
      wr_go     = '0;
      pre_go    = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         is_closed[i] = (st_q[i] == B_CLOSED);
         is_open[i]   = (st_q[i] == B_OPEN);
         is_busy[i]   = (st_q[i] == B_ACTIVATING) || (st_q[i] == B_PRECHARGING);
         pre_ok[i]    = is_open[i] && (ras_q[i] == '0) && (wr_q[i] == '0);
         bank_open[i] = (st_q[i] == B_ACTIVATING) || (st_q[i] == B_OPEN);
         act_go[i]    = accept && (cmd_type == C_ACT) && (cmd_bank == BW'(i));
         wr_go[i]     = accept && (cmd_type == C_WR) && (cmd_bank == BW'(i));
         // PREA closes only the banks that are actually open
         pre_go[i]    = accept && is_open[i] &&
                        (((cmd_type == C_PRE) && (cmd_bank == BW'(i))) || (cmd_type == C_PREA));
      end
   end

   always_comb begin
      cmd_legal = 1'b0;
      case (cmd_type)
         C_ACT:       cmd_legal = is_closed[cmd_bank];
         C_RD, C_WR:  cmd_legal = is_open[cmd_bank];
         C_PRE:       cmd_legal = pre_ok[cmd_bank];
         C_PREA:      cmd_legal = (is_busy == '0) && ((is_open & ~pre_ok) == '0);
         C_REF:       cmd_legal = &is_closed;
         default:     cmd_legal = 1'b0;
      endcase
      if (refreshing) cmd_legal = 1'b0;
   end

   assign cmd_row_hit = is_open[cmd_bank] && (row_q[cmd_bank] == cmd_row);
   assign accept      = cmd_valid && cmd_legal;
   assign ref_acc     = accept && (cmd_type == C_REF);
   assign wrap        = (timer_q == CNT_W'(T_REFI - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            st_q[i]  <= B_CLOSED;
            cnt_q[i] <= '0;
            ras_q[i] <= '0;
            wr_q[i]  <= '0;
            row_q[i] <= '0;
         end
         ref_cnt_q   <= '0;
         timer_q     <= '0;
         refreshing  <= 1'b0;
         illegal_cmd <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            ras_q[i] <= act_go[i] ? CNT_W'(T_RAS - 1) : dec_sat(ras_q[i]);
            wr_q[i]  <= wr_go[i] ? CNT_W'(T_WL + T_BURST + T_WR - 1) : dec_sat(wr_q[i]);
            // Leave the transient states one cycle early so the next command is legal exactly T cycles after
            case (st_q[i])
               B_CLOSED: if (act_go[i]) begin
                  st_q[i]  <= (T_RCD > 1) ? B_ACTIVATING : B_OPEN;
                  cnt_q[i] <= CNT_W'(T_RCD - 1);
                  row_q[i] <= cmd_row;
               end
               B_ACTIVATING: begin
                  cnt_q[i] <= dec_sat(cnt_q[i]);
                  if (cnt_q[i] <= ONE) st_q[i] <= B_OPEN;
               end
               B_OPEN: if (pre_go[i]) begin
                  st_q[i]  <= (T_RP > 1) ? B_PRECHARGING : B_CLOSED;
                  cnt_q[i] <= CNT_W'(T_RP - 1);
               end
               B_PRECHARGING: begin
                  cnt_q[i] <= dec_sat(cnt_q[i]);
                  if (cnt_q[i] <= ONE) st_q[i] <= B_CLOSED;
               end
               default: st_q[i] <= B_CLOSED;
            endcase
         end
         timer_q     <= wrap ? '0 : timer_q + ONE;
         illegal_cmd <= cmd_valid && !cmd_legal;
         if (ref_acc) begin
            refreshing <= (T_RFC > 1);
            ref_cnt_q  <= CNT_W'(T_RFC - 1);
         end else if (refreshing) begin
            ref_cnt_q <= dec_sat(ref_cnt_q);
            if (ref_cnt_q <= ONE) refreshing <= 1'b0;
         end
      end
   end

`ifdef DRAM_REF_POSTPONE_EN
   logic [3:0] debt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         debt_q       <= 4'd0;
         ref_overflow <= 1'b0;
      end else begin
         ref_overflow <= 1'b0;
         if (wrap && !ref_acc) begin
            if (debt_q == 4'd8) ref_overflow <= 1'b1;
            else                debt_q       <= debt_q + 4'd1;
         end else if (ref_acc && !wrap && (debt_q != 4'd0)) begin
            debt_q <= debt_q - 4'd1;
         end
      end
   end

   assign ref_req = (debt_q != 4'd0);
`else
   always_ff @(posedge CLK) begin
      if (RST) begin
         ref_req      <= 1'b0;
         ref_overflow <= 1'b0;
      end else begin
         ref_overflow <= wrap && !ref_acc && ref_req;
         if (wrap && !ref_acc)      ref_req <= 1'b1;
         else if (ref_acc && !wrap) ref_req <= 1'b0;
      end
   end
`endif
endmodule
